nibble_add_arbiter: RTL

Round-robin arbiter and sequencer sharing one registered 4-bit nibble adder among several requesters. Each requester presents an operand pair via valid/ready; the block grants one requester at a time, captures its operands, computes the sum in the shared adder, and returns the result tagged with the requester index over a valid/ready result port. It sits between the top-level pin logic (`ui_in` nibbles, per-requester sources) and the `uo_out` result path.

---
 rtl/nibble_add_pkg.sv | 18 +
 rtl/nibble_add_arbiter_rr.sv | 39 +++
 rtl/nibble_add_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/nibble_add_pkg.sv
// Shared constants and types for the nibble adder arbiter slice.
package nibble_add_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int W_DEF       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [$clog2(NUM_REQ_DEF)-1:0] id;
    logic [W_DEF:0]                 sum;
  } result_t;

endpackage

// File: rtl/nibble_add_arbiter_rr.sv
// Combinational round-robin arbiter: lowest index above last_grant wins, else
// lowest index at or below it. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id
);

  logic w_found;
  int   w_lg;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    w_found  = 1'b0;
    w_lg     = int'(last_grant);
    // First pass covers the indices after the pointer, second pass wraps around.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (enable && !w_found && req[i] && (i > w_lg)) begin
        grant[i] = 1'b1;
        grant_id = IDW'(i);
        w_found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (enable && !w_found && req[i] && (i <= w_lg)) begin
        grant[i] = 1'b1;
        grant_id = IDW'(i);
        w_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nibble_add_arbiter.sv
// Round-robin sequencer sharing one registered nibble adder between requesters.
// Define NIBBLE_ADD_CARRY_EN to return the adder carry-out in res_sum[W].
module nibble_add_arbiter
  import nibble_add_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int W       = W_DEF,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [W:0]           res_sum,
  output logic [IDW-1:0]       res_id,
  output logic                 busy
);

  function automatic logic [W:0] add_nibble(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b};
`ifdef NIBBLE_ADD_CARRY_EN
    return full;
`else
    return {1'b0, full[W-1:0]};
`endif
  endfunction

  state_e           r_state;
  logic [IDW-1:0]   r_last_grant;
  logic             r_rst_hold;
  logic [W-1:0]     r_op_a_p0;
  logic [W-1:0]     r_op_b_p0;
  logic [IDW-1:0]   r_id_p0;
  logic             r_vld_p1;
  logic [W:0]       r_res_sum_p1;
  logic [IDW-1:0]   r_res_id_p1;

  logic               w_arb_en;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_grant_id;
  logic               w_accept;
  logic [W-1:0]       w_sel_a;
  logic [W-1:0]       w_sel_b;

  // Grants are withheld during reset and for one cycle after it.
  assign w_arb_en = (r_state == IDLE) && !r_rst_hold && !reset;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .enable     (w_arb_en),
    .grant      (w_grant),
    .grant_id   (w_grant_id)
  );

  assign req_ready = w_grant;
  assign w_accept  = |(w_grant & req_valid);

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = req_a[i*W +: W];
        w_sel_b = req_b[i*W +: W];
      end
    end
  end

  // Stage p0: operand capture on an accepted request.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op_a_p0 <= w_sel_a;
      r_op_b_p0 <= w_sel_b;
    end
  end

  // Stage p1: shared adder result and the sequencing FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= IDW'(NUM_REQ - 1);
      r_rst_hold   <= 1'b1;
      r_id_p0      <= '0;
      r_vld_p1     <= 1'b0;
      r_res_sum_p1 <= '0;
      r_res_id_p1  <= '0;
    end else begin
      r_rst_hold <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id_p0      <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_state      <= CALC;
          end
        end
        CALC: begin
          r_res_sum_p1 <= add_nibble(r_op_a_p0, r_op_b_p0);
          r_res_id_p1  <= r_id_p0;
          r_vld_p1     <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (r_vld_p1 && res_ready) begin
            r_vld_p1 <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign res_valid = r_vld_p1;
  assign res_sum   = r_res_sum_p1;
  assign res_id    = r_res_id_p1;
  assign busy      = (r_state != IDLE);

  a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

  a_result_hold: assert property (@(posedge clk) disable iff (reset)
    (r_vld_p1 && !res_ready) |=> (r_vld_p1 && $stable(r_res_sum_p1) && $stable(r_res_id_p1)));

endmodule
